// File: rtl/usb_transmitter.sv
// rtl/usb_transmitter.sv - USB packet transmitter: SYNC, NRZI-encoded data LSB-first, EOP.
// Optional bit stuffing (stuffed 0 after six consecutive 1s) is enabled by defining BIT_STUFF_EN.
module usb_transmitter #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_read,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          level;
  logic          eop_cnt;
  logic          bit_end;
  logic          stuff_due;
  logic          send_bit;
  logic          send_lvl;

`ifdef BIT_STUFF_EN
  logic [2:0]    ones_cnt;
  // The stuffed bit itself clears ones_cnt, so it can never request a second stuff.
  assign stuff_due = (ones_cnt == 3'd6);
`else
  assign stuff_due = 1'b0;
`endif

  assign bit_end = (bit_cnt == CNT_MAX);

  assign tx_read = ((state == SYNC) || (state == DATA)) && bit_end &&
                   (bit_idx == 3'd7) && !stuff_due && !tx_empty;

  // Bit to put on the line at the coming boundary: stuffed 0, next bit of the byte,
  // or bit 0 of the byte being fetched.
  always_comb begin
    send_bit = 1'b0;
    if (!stuff_due)
      send_bit = (bit_idx == 3'd7) ? tx_data[0] : shreg[bit_idx + 3'd1];
    send_lvl = send_bit ? level : ~level;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      level   <= 1'b1;
      eop_cnt <= 1'b0;
      d_plus  <= 1'b1;
      d_minus <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef BIT_STUFF_EN
      ones_cnt <= '0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
`ifdef BIT_STUFF_EN
          ones_cnt <= '0;
`endif
          if (tx_start) begin
            // First SYNC bit is a 0, so the line toggles from J to K right away.
            state   <= SYNC;
            shreg   <= 8'h80;
            tx_busy <= 1'b1;
            level   <= ~level;
            d_plus  <= ~level;
            d_minus <= level;
          end
        end
        SYNC, DATA: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
          if (bit_end) begin
            if (stuff_due || (bit_idx != 3'd7) || !tx_empty) begin
              level   <= send_lvl;
              d_plus  <= send_lvl;
              d_minus <= ~send_lvl;
`ifdef BIT_STUFF_EN
              ones_cnt <= send_bit ? ones_cnt + 3'd1 : 3'd0;
`endif
              if (!stuff_due) begin
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
                  state <= DATA;
                  shreg <= tx_data;
                end
              end
            end else begin
              state   <= EOP_SE0;
              eop_cnt <= 1'b0;
              d_plus  <= 1'b0;
              d_minus <= 1'b0;
`ifdef BIT_STUFF_EN
              ones_cnt <= '0;
`endif
            end
          end
        end
        EOP_SE0: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
          if (bit_end) begin
            if (eop_cnt) begin
              state   <= EOP_J;
              level   <= 1'b1;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end else begin
              eop_cnt <= 1'b1;
            end
          end
        end
        EOP_J: begin
          bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
          if (bit_cnt == CNT_DONE)
            tx_done <= 1'b1;
          if (bit_end) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_transmitter.sv
// tb/tb_usb_transmitter.sv - Randomized bench for usb_transmitter against a packet-level line model.
module tb_usb_transmitter;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_empty = 1'b1;
  logic       tx_read, d_plus, d_minus, tx_busy, tx_done;

  int         n_pass = 0;
  int         n_total = 0;
  int         rd_cnt = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mq[$];
  logic [7:0] fifo[$];
  logic [4:0] cmp_exp;
  logic [7:0] pkt[$];

  usb_transmitter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
    .tx_empty(tx_empty), .tx_read(tx_read), .d_plus(d_plus), .d_minus(d_minus),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Per-cycle expectation {d_plus, d_minus, tx_busy, tx_read, tx_done}, cycle 0 = after start edge.
  task automatic build_model(input logic [7:0] b[$]);
    bit         bits[$];
    int         ends[$];
    logic       lvl;
    logic [7:0] cur;
    bit         rd_here;
`ifdef BIT_STUFF_EN
    int         ones;
    ones = 0;
`endif
    mq.delete();
    lvl = 1'b1;
    for (int j = 0; j <= b.size(); j++) begin
      cur = (j == 0) ? 8'h80 : b[j-1];
      for (int i = 0; i < 8; i++) begin
        bits.push_back(cur[i]);
`ifdef BIT_STUFF_EN
        ones = cur[i] ? ones + 1 : 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
`endif
      end
      ends.push_back(bits.size() - 1);
    end
    for (int k = 0; k < bits.size(); k++) begin
      rd_here = 1'b0;
      if (!bits[k]) lvl = ~lvl;
      for (int j = 0; j < b.size(); j++)
        if (ends[j] == k) rd_here = 1'b1;
      for (int c = 0; c < CPB; c++)
        mq.push_back({lvl, ~lvl, 1'b1, rd_here && (c == CPB - 1), 1'b0});
    end
    for (int c = 0; c < 2 * CPB; c++) mq.push_back(5'b00100);
    for (int c = 0; c < CPB; c++) mq.push_back({4'b1010, c == CPB - 1});
  endtask

  function automatic int first_rd();
    for (int i = 0; i < mq.size(); i++) if (mq[i][1]) return i;
    return -1;
  endfunction

  function automatic int count_rd();
    int n = 0;
    for (int i = 0; i < mq.size(); i++) if (mq[i][1]) n++;
    return n;
  endfunction

  function automatic logic [7:0] dp_pat(input int base);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) p = {p[6:0], mq[base + CPB * i][4]};
    return p;
  endfunction

  // Compare process: every negedge, DUT outputs against the model (idle J when no packet pending).
  initial forever begin
    @(negedge clk);
    if (tx_read) rd_cnt++;
    if (exp_q.size() > 0) cmp_exp = exp_q.pop_front();
    else cmp_exp = 5'b10000;
    check("cycle", {27'd0, d_plus, d_minus, tx_busy, tx_read, tx_done}, {27'd0, cmp_exp});
  end

  // First-word-fall-through FIFO: pops one entry per observed tx_read.
  initial begin
    int pops = 0;
    forever begin
      @(posedge clk);
      #1;
      while (pops < rd_cnt) begin
        if (fifo.size() > 0) void'(fifo.pop_front());
        pops++;
      end
      tx_empty = (fifo.size() == 0);
      tx_data  = tx_empty ? 8'($urandom) : fifo[0];
    end
  end

  task automatic start_packet(input logic [7:0] b[$]);
    build_model(b);
    @(posedge clk); #2;
    foreach (b[i]) fifo.push_back(b[i]);
    repeat (2) @(posedge clk);
    #2 tx_start = 1'b1;
    @(posedge clk);
    #2 tx_start = 1'b0;
    foreach (mq[i]) exp_q.push_back(mq[i]);
  endtask

  task automatic finish_packet();
    for (int c = 0; c < 4000 && exp_q.size() > 0; c++) @(posedge clk);
    if (exp_q.size() > 0) begin
      check("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat ($urandom_range(4, 1)) @(posedge clk);
  endtask

  task automatic run_packet(input logic [7:0] b[$], input bit poke);
    int k;
    start_packet(b);
    if (poke) begin
      k = $urandom_range(mq.size() - 2, 1);
      repeat (k) @(posedge clk);
      #2 tx_start = 1'b1;
      @(posedge clk);
      #2 tx_start = 1'b0;
    end
    finish_packet();
  endtask

  initial begin
    // Reset held with tx_start high: line must stay idle J.
    tx_start = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("reset_state", {d_plus, d_minus, tx_busy, tx_read, tx_done}, 5'b10000);
    tx_start = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    pkt = '{8'hA5};
    build_model(pkt);
    check("model_a5_len", mq.size(), 152);
    check("model_a5_rd_at", first_rd(), 63);
    check("model_a5_rd_cnt", count_rd(), 1);
    check("model_a5_sync", dp_pat(0), 8'h54);
    check("model_a5_data", dp_pat(64), 8'h6C);
    check("model_a5_c63", mq[63], 5'b01110);
    check("model_a5_done", mq[151], 5'b10101);
    run_packet(pkt, 1'b0);

    pkt.delete();
    build_model(pkt);
    check("model_zlp_len", mq.size(), 88);
    check("model_zlp_rd_cnt", count_rd(), 0);
    check("model_zlp_se0", mq[64], 5'b00100);
    run_packet(pkt, 1'b1);

    pkt = '{8'h01, 8'h02};
    build_model(pkt);
    check("model_0102_rd1", first_rd(), 63);
    check("model_0102_rd2", mq[127][1], 1);
    check("model_0102_b0", dp_pat(64), 8'h55);
    check("model_0102_b1", dp_pat(128), 8'h2A);
    run_packet(pkt, 1'b0);

    pkt = '{8'hFF};
    build_model(pkt);
`ifdef BIT_STUFF_EN
    check("model_ff_len", mq.size(), 160);
`else
    check("model_ff_len", mq.size(), 152);
`endif
    run_packet(pkt, 1'b0);

    // Reset during the third data bit aborts to idle J with no EOP or tx_done.
    pkt = '{8'h3C, 8'h77};
    start_packet(pkt);
    repeat (83) @(posedge clk);
    #2 n_rst = 1'b0;
    exp_q.delete();
    #1 check("reset_abort", {d_plus, d_minus, tx_busy, tx_read, tx_done}, 5'b10000);
    fifo.delete();
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (2) @(posedge clk);
    run_packet(pkt, 1'b0);

    for (int t = 0; t < 12; t++) begin
      pkt.delete();
      for (int i = 0; i < $urandom_range(3, 0); i++) pkt.push_back(8'($urandom));
      if (t == 5) pkt = '{8'hFF, 8'h3F, 8'hFE};
      run_packet(pkt, 1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
